// File: rtl/xsvi_timing_gen.sv
// rtl/xsvi_timing_gen.sv - XSVI raster timing generator with test-pattern and passthrough pixel sources.
module xsvi_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_W   = 24,
  parameter int CNT_W    = 12
) (
  input  logic              Bus2IP_Clk,
  input  logic              Bus2IP_Resetn,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] solid_color,
  input  logic [DATA_W-1:0] pix_data_in,
  input  logic              pix_valid,
  input  logic              clr_err,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              xsvi_h_sync,
  output logic              xsvi_v_sync,
  output logic              xsvi_video_active,
  output logic [DATA_W-1:0] xsvi_video_data,
  output logic              frame_start,
  output logic              err_underflow
);
  localparam int CW      = DATA_W / 3;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0]  h_cnt, v_cnt, bar_pos;
  logic [2:0]        bar_idx;
  logic [1:0]        mode_q, mode_eff;
  logic [DATA_W-1:0] color_q, color_eff, pix_next;
  logic [CW-1:0]     frame_cnt;
  logic              h_wrap, v_wrap, hs, vs, act, first, underflow;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign hs     = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs     = (v_cnt >= V_SS) && (v_cnt < V_SE);
  assign act    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign first  = enable && (h_cnt == '0) && (v_cnt == '0);

  assign pix_req = act && enable;
  assign pix_x   = pix_req ? h_cnt : '0;
  assign pix_y   = pix_req ? v_cnt : '0;

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      if (v_wrap) frame_cnt <= frame_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Bar index advances every BAR_W active pixels and saturates at the last bar.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (!enable || h_wrap) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (h_cnt < H_ACT_C) begin
      if (bar_pos == BAR_LAST) begin
        bar_pos <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + 1'b1;
      end
    end
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      mode_q  <= '0;
      color_q <= '0;
    end else if (first) begin
      mode_q  <= mode;
      color_q <= solid_color;
    end
  end

  // The first pixel of a frame uses the inputs being latched in that same cycle.
  assign mode_eff  = first ? mode : mode_q;
  assign color_eff = first ? solid_color : color_q;

  always_comb begin
    pix_next  = '0;
    underflow = 1'b0;
    if (pix_req) begin
      case (mode_eff)
        2'd0: begin
          if (pix_valid) pix_next = pix_data_in;
          else           underflow = 1'b1;
        end
        2'd1:    pix_next = {{CW{~bar_idx[1]}}, {CW{~bar_idx[2]}}, {CW{~bar_idx[0]}}};
        2'd2:    pix_next = color_eff;
        default: pix_next = {CW'(h_cnt), CW'(v_cnt), frame_cnt};
      endcase
    end
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      xsvi_h_sync       <= ~HS_POL;
      xsvi_v_sync       <= ~VS_POL;
      xsvi_video_active <= 1'b0;
      xsvi_video_data   <= '0;
      frame_start       <= 1'b0;
    end else begin
      xsvi_h_sync       <= (enable && hs) ? HS_POL : ~HS_POL;
      xsvi_v_sync       <= (enable && vs) ? VS_POL : ~VS_POL;
      xsvi_video_active <= pix_req;
      xsvi_video_data   <= pix_next;
      frame_start       <= first;
    end
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn)  err_underflow <= 1'b0;
    else if (underflow)  err_underflow <= 1'b1;
    else if (clr_err)    err_underflow <= 1'b0;
  end
endmodule

// File: tb/tb_xsvi_timing_gen.sv
// tb/tb_xsvi_timing_gen.sv - directed self-checking bench for xsvi_timing_gen on a 16x8 raster.
module tb_xsvi_timing_gen;
  localparam int DATA_W = 24;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [1:0]        mode = 2'd2;
  logic [DATA_W-1:0] solid_color = 24'h123456;
  logic [DATA_W-1:0] pix_data_in = '0;
  logic              pix_valid = 1'b1;
  logic              clr_err = 1'b0;
  logic              pix_req;
  logic [CNT_W-1:0]  pix_x, pix_y;
  logic              xsvi_h_sync, xsvi_v_sync, xsvi_video_active, frame_start, err_underflow;
  logic [DATA_W-1:0] xsvi_video_data;

  xsvi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .enable(enable), .mode(mode),
    .solid_color(solid_color), .pix_data_in(pix_data_in), .pix_valid(pix_valid),
    .clr_err(clr_err), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .xsvi_h_sync(xsvi_h_sync), .xsvi_v_sync(xsvi_v_sync),
    .xsvi_video_active(xsvi_video_active), .xsvi_video_data(xsvi_video_data),
    .frame_start(frame_start), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  int   uf_k = -1;
  int   nv_lo = 0;
  int   nv_hi = 0;
  logic err_exp = 1'b0;
  int   fmode [0:15];
  logic [23:0] bars [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Outputs seen now belong to counter state k; pix_req already reflects state k+1.
  task automatic check_state();
    int h = k % 16;
    int v = (k / 16) % 8;
    int f = k / 128;
    int hn = (k + 1) % 16;
    int vn = ((k + 1) / 16) % 8;
    logic a  = (h < 8) && (v < 4);
    logic an = (hn < 8) && (vn < 4);
    logic [23:0] d;
    if (k == uf_k) err_exp = 1'b1;
    case (fmode[f])
      0:       d = (k == uf_k) ? 24'h0 : {12'(v), 12'(h)};
      1:       d = bars[h % 8];
      2:       d = 24'h123456;
      default: d = {8'(h), 8'(v), 8'(f)};
    endcase
    if (!a) d = '0;
    check("active", 32'(xsvi_video_active), 32'(a));
    check("h_sync", 32'(xsvi_h_sync), 32'(!(h >= 10 && h < 13)));
    check("v_sync", 32'(xsvi_v_sync), 32'(!(v >= 5 && v < 7)));
    check("frame_start", 32'(frame_start), 32'(k % 128 == 0));
    check("data", 32'(xsvi_video_data), 32'(d));
    check("err", 32'(err_underflow), 32'(err_exp));
    check("pix_req", 32'(pix_req), 32'(an));
    check("pix_x", 32'(pix_x), an ? 32'(hn) : 32'd0);
    check("pix_y", 32'(pix_y), an ? 32'(vn) : 32'd0);
  endtask

  task automatic prep();
    int h = k % 16;
    int v = (k / 16) % 8;
    pix_data_in = ((h < 8) && (v < 4)) ? {12'(v), 12'(h)} : 24'hABCDEF;
    pix_valid   = !((k == uf_k) || (k >= nv_lo && k < nv_hi));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_state();
      k++;
      prep();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_active"}, 32'(xsvi_video_active), 32'd0);
    check({tag, "_data"}, 32'(xsvi_video_data), 32'd0);
    check({tag, "_h_sync"}, 32'(xsvi_h_sync), 32'd1);
    check({tag, "_v_sync"}, 32'(xsvi_v_sync), 32'd1);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fmode[i] = 1;
    fmode[0] = 2; fmode[1] = 2; fmode[2] = 2; fmode[3] = 1;
    fmode[4] = 0; fmode[5] = 0; fmode[6] = 0; fmode[7] = 1;

    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_err", 32'(err_underflow), 32'd0);
    check("rst_pix_req", 32'(pix_req), 32'd0);

    // Solid timing, mode switch at line 2 of frame 2, passthrough, underflow at (3,1) of frame 5.
    uf_k = 5 * 128 + 16 + 3;
    nv_lo = 7 * 128;
    nv_hi = 8 * 128;
    k = 0;
    prep();
    enable = 1'b1;
    rst_n = 1'b1;
    run(2 * 128 + 32);
    mode = 2'd1;
    run(3 * 128 + 64 - k);
    mode = 2'd0;
    run(7 * 128 - k);
    clr_err = 1'b1;
    mode = 2'd1;
    err_exp = 1'b0;
    run(1);
    clr_err = 1'b0;
    run(8 * 128 + 20 - k);

    // Asynchronous reset mid-line, then gradient frames from a cleared frame counter.
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_err", 32'(err_underflow), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) fmode[i] = 3;
    uf_k = -1;
    nv_hi = 0;
    mode = 2'd3;
    k = 0;
    prep();
    rst_n = 1'b1;
    run(2 * 128 + 10);

    // Enable dropped for 5 cycles, then a clean restart in solid mode.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("dis");
      check("dis_pix_req", 32'(pix_req), 32'd0);
      check("dis_pix_x", 32'(pix_x), 32'd0);
    end
    for (int i = 0; i < 16; i++) fmode[i] = 2;
    mode = 2'd2;
    k = 0;
    prep();
    enable = 1'b1;
    run(140);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
